// File: rtl/ram_rr_arbiter_if.sv
// rtl/ram_rr_arbiter_if.sv - requester-side and RAM-pin signal bundle for ram_rr_arbiter
interface ram_rr_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 13
);
    logic [NREQ-1:0]    req_i;
    logic [NREQ-1:0]    we_i;
    logic [4*NREQ-1:0]  sel_i;
    logic [AW*NREQ-1:0] adr_i;
    logic [32*NREQ-1:0] dat_i;
    logic [NREQ-1:0]    ack_o;
    logic [NREQ-1:0]    err_o;
    logic [31:0]        dat_o;
    logic               busy_o;
    logic               ram_en;
    logic [3:0]         ram_we;
    logic [AW-1:0]      ram_a;
    logic [31:0]        ram_di;
    logic [31:0]        ram_do;

    // arbiter side
    modport slave (
        input  req_i, we_i, sel_i, adr_i, dat_i, ram_do,
        output ack_o, err_o, dat_o, busy_o, ram_en, ram_we, ram_a, ram_di
    );

    // requesters plus RAM macro side
    modport master (
        output req_i, we_i, sel_i, adr_i, dat_i, ram_do,
        input  ack_o, err_o, dat_o, busy_o, ram_en, ram_we, ram_a, ram_di
    );
endinterface

// File: rtl/ram_rr_arbiter.sv
// rtl/ram_rr_arbiter.sv - round-robin arbiter sharing one single-port user-area RAM
module ram_rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int AW    = 13,
    parameter int DEPTH = 6144
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    ram_rr_arbiter_if.slave bus
);
    localparam int          GW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [GW-1:0]   last;
    logic [GW-1:0]   gnt;
    logic [GW-1:0]   pick;
    logic            any_req;
    logic            ok;
    logic            rd;
    logic            pick_we;
    logic [3:0]      pick_sel;
    logic [AW-1:0]   pick_adr;
    logic [31:0]     pick_dat;
    logic            pick_ok;
    logic [NREQ-1:0] gnt_oh;

    assign any_req = |bus.req_i;
    assign gnt_oh  = NREQ'(1) << gnt;

    // scan last+1, last+2, ... (mod NREQ) and take the first requesting port
    always_comb begin
        int              idx;
        logic [NREQ-1:0] rot;
        logic            found;
        pick  = last;
        found = 1'b0;
        idx   = 0;
        rot   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last) + i) % NREQ;
            rot = bus.req_i >> idx;
            if (!found && rot[0]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
    end

    // qualifiers of the candidate port and its range check
    always_comb begin
        pick_we  = 1'(bus.we_i >> pick);
        pick_sel = 4'(bus.sel_i >> (4 * int'(pick)));
        pick_adr = AW'(bus.adr_i >> (AW * int'(pick)));
        pick_dat = 32'(bus.dat_i >> (32 * int'(pick)));
        pick_ok  = ({1'b0, pick_adr} < DEPTH_W);
    end

    // state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // one cycle each in ISSUE and DONE, leave IDLE only when someone asks
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // grant latch, registered RAM pins and completion pulses
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            last       <= GW'(NREQ - 1);
            gnt        <= '0;
            ok         <= 1'b0;
            rd         <= 1'b0;
            bus.ram_en <= 1'b0;
            bus.ram_we <= 4'b0;
            bus.ram_a  <= '0;
            bus.ram_di <= 32'h0;
            bus.ack_o  <= '0;
            bus.err_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt        <= pick;
                        last       <= pick;
                        ok         <= pick_ok;
                        rd         <= !pick_we;
                        bus.ram_en <= pick_ok;
                        bus.ram_we <= (pick_ok && pick_we) ? pick_sel : 4'b0;
                        // out-of-range addresses never reach the RAM pins
                        if (pick_ok) begin
                            bus.ram_a  <= pick_adr;
                            bus.ram_di <= pick_dat;
                        end
                    end
                end
                ISSUE: begin
                    bus.ram_en <= 1'b0;
                    bus.ram_we <= 4'b0;
                    bus.ack_o  <= ok ? gnt_oh : '0;
                    bus.err_o  <= ok ? '0 : gnt_oh;
                end
                DONE: begin
                    bus.ack_o <= '0;
                    bus.err_o <= '0;
                end
                default: begin
                    bus.ram_en <= 1'b0;
                    bus.ram_we <= 4'b0;
                    bus.ack_o  <= '0;
                    bus.err_o  <= '0;
                end
            endcase
        end
    end

    assign bus.busy_o = (state != IDLE);
    // RAM output is valid in DONE, one cycle after the enable cycle
    assign bus.dat_o  = (state == DONE && ok && rd) ? bus.ram_do : 32'h0;
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb/tb_ram_rr_arbiter.sv - randomized self-checking bench for ram_rr_arbiter
module tb_ram_rr_arbiter;
    localparam int NREQ  = 2;
    localparam int AW    = 13;
    localparam int DEPTH = 6144;

    typedef struct {
        logic          we;
        logic [3:0]    sel;
        logic [AW-1:0] adr;
        logic [31:0]   dat;
    } txn_t;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    logic ram_clr  = 1'b1;

    always #5 wb_clk_i = ~wb_clk_i;

    ram_rr_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

    ram_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DEPTH(DEPTH)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    // RAM macro: synchronous read, byte-lane writes
    logic [31:0] ram_mem [DEPTH];
    always @(posedge wb_clk_i) begin
        if (ram_clr) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 32'h0;
        end else if (bus.ram_en && int'(bus.ram_a) < DEPTH) begin
            bus.ram_do <= ram_mem[bus.ram_a];
            for (int b = 0; b < 4; b++)
                if (bus.ram_we[b]) ram_mem[bus.ram_a][8*b +: 8] <= bus.ram_di[8*b +: 8];
        end
    end

    int compared   = 0;
    int mismatched = 0;

    // reference model: word memory, request queues, grant bookkeeping
    logic [31:0]     exp_mem [DEPTH];
    txn_t            q [NREQ][$];
    txn_t            cur [NREQ];
    logic [NREQ-1:0] active;
    int              raise_pct;
    int              cyc;
    int              gc;
    int              gport;
    int              last_m;
    txn_t            gt;
    logic            gok;
    bit              rst_at_issue;
    int              seen_port[$];
    int              seen_cyc[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic txn_t mk_txn(input logic we, input logic [3:0] sel,
                                    input logic [AW-1:0] adr, input logic [31:0] dat);
        txn_t t;
        t.we  = we;
        t.sel = sel;
        t.adr = adr;
        t.dat = dat;
        return t;
    endfunction

    function automatic txn_t rand_txn(input int oor_pct);
        txn_t t;
        t.we  = 1'($urandom_range(0, 1));
        t.sel = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 99) < oor_pct) t.adr = AW'($urandom_range(DEPTH, (1 << AW) - 1));
        else                                 t.adr = AW'($urandom_range(0, 31));
        t.dat = $urandom;
        return t;
    endfunction

    function automatic int pending();
        int n = $countones(active);
        for (int k = 0; k < NREQ; k++) n += q[k].size();
        return n;
    endfunction

    task automatic drive_port(input int k, input logic req, input txn_t t);
        bus.req_i[k]           = req;
        bus.we_i[k]            = t.we;
        bus.sel_i[4*k +: 4]    = t.sel;
        bus.adr_i[AW*k +: AW]  = t.adr;
        bus.dat_i[32*k +: 32]  = t.dat;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, bus.busy_o, 1'b0);
        check_eq({tag, "_ack"}, bus.ack_o, '0);
        check_eq({tag, "_err"}, bus.err_o, '0);
        check_eq({tag, "_dat_o"}, bus.dat_o, 32'h0);
        check_eq({tag, "_ram_en"}, bus.ram_en, 1'b0);
        check_eq({tag, "_ram_we"}, bus.ram_we, 4'h0);
        check_eq({tag, "_ram_a"}, bus.ram_a, '0);
        check_eq({tag, "_ram_di"}, bus.ram_di, 32'h0);
    endtask

    task automatic step();
        logic            issue;
        logic            done;
        logic [NREQ-1:0] e_ack;
        logic [NREQ-1:0] e_err;
        logic [31:0]     e_dat;
        bit              found;
        int              p;
        @(negedge wb_clk_i);
        cyc++;
        issue = (cyc == gc + 1);
        done  = (cyc == gc + 2);
        e_ack = '0;
        e_err = '0;
        e_dat = 32'h0;
        if (done) begin
            if (gok) e_ack[gport] = 1'b1;
            else     e_err[gport] = 1'b1;
            if (gok && !gt.we) e_dat = exp_mem[gt.adr];
        end
        check_eq("busy", bus.busy_o, issue || done);
        check_eq("ack", bus.ack_o, e_ack);
        check_eq("err", bus.err_o, e_err);
        check_eq("dat_o", bus.dat_o, e_dat);
        check_eq("ram_en", bus.ram_en, issue && gok);
        check_eq("ram_we", bus.ram_we, (issue && gok && gt.we) ? gt.sel : 4'b0);
        if (issue && gok) begin
            check_eq("ram_a", bus.ram_a, gt.adr);
            if (gt.we) check_eq("ram_di", bus.ram_di, gt.dat);
        end
        for (int k = 0; k < NREQ; k++)
            if (bus.ack_o[k] || bus.err_o[k]) begin
                seen_port.push_back(k);
                seen_cyc.push_back(cyc);
            end
        if (done && gok && gt.we)
            for (int b = 0; b < 4; b++)
                if (gt.sel[b]) exp_mem[gt.adr][8*b +: 8] = gt.dat[8*b +: 8];

        if (issue && rst_at_issue) begin
            rst_at_issue = 1'b0;
            wb_rst_i = 1'b1;
            #1;
            check_quiet("midrst");
            #1;
            wb_rst_i = 1'b0;
            gc     = -100;
            last_m = NREQ - 1;
        end

        for (int k = 0; k < NREQ; k++) begin
            if (active[k] && (bus.ack_o[k] || bus.err_o[k])) begin
                active[k] = 1'b0;
                drive_port(k, 1'b0, rand_txn(50));
            end else if (!active[k] && q[k].size() > 0 && $urandom_range(0, 99) < raise_pct) begin
                cur[k]    = q[k].pop_front();
                active[k] = 1'b1;
                drive_port(k, 1'b1, cur[k]);
            end else if (!active[k]) begin
                drive_port(k, 1'b0, rand_txn(50));
            end
        end

        if (cyc >= gc + 3 && active != '0) begin
            found = 1'b0;
            for (int i = 1; i <= NREQ; i++) begin
                p = (last_m + i) % NREQ;
                if (!found && active[p]) begin
                    gport = p;
                    found = 1'b1;
                end
            end
            gt     = cur[gport];
            gok    = (int'(gt.adr) < DEPTH);
            last_m = gport;
            gc     = cyc;
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (!(pending() == 0 && cyc >= gc + 3)) begin
            if (n >= budget) begin
                check_eq("drain_timeout", pending(), 0);
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        check_quiet("rst");
        wb_rst_i = 1'b0;
        gc     = -100;
        last_m = NREQ - 1;
    endtask

    task automatic check_cadence(input string tag, input int n, input int first);
        check_eq({tag, "_count"}, seen_port.size(), n);
        if (seen_port.size() == n)
            for (int i = 0; i < n; i++) begin
                check_eq({tag, "_port"}, seen_port[i], (first < 0) ? (i % NREQ) : first);
                if (i > 0) check_eq({tag, "_gap"}, seen_cyc[i] - seen_cyc[i-1], 3);
            end
    endtask

    initial begin
        bus.req_i  = '0;
        bus.we_i   = '0;
        bus.sel_i  = '0;
        bus.adr_i  = '0;
        bus.dat_i  = '0;
        active     = '0;
        raise_pct  = 100;
        cyc        = 0;
        gc         = -100;
        gport      = 0;
        last_m     = NREQ - 1;
        gt         = mk_txn(1'b0, 4'h0, '0, 32'h0);
        gok        = 1'b0;
        rst_at_issue = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;

        repeat (3) @(negedge wb_clk_i);
        ram_clr = 1'b0;
        check_quiet("reset");
        wb_rst_i = 1'b0;

        // write then read back on port 0
        q[0].push_back(mk_txn(1'b1, 4'hF, AW'(5), 32'hDEADBEEF));
        q[0].push_back(mk_txn(1'b0, 4'hF, AW'(5), 32'h0));
        run_until_idle(100);

        // partial byte-lane write on port 1
        q[1].push_back(mk_txn(1'b1, 4'hF, AW'(7), 32'h11223344));
        q[1].push_back(mk_txn(1'b1, 4'b0010, AW'(7), 32'h0000AB00));
        q[1].push_back(mk_txn(1'b0, 4'h0, AW'(7), 32'h0));
        q[1].push_back(mk_txn(1'b1, 4'h0, AW'(7), 32'hFFFFFFFF));
        q[1].push_back(mk_txn(1'b0, 4'hF, AW'(7), 32'h0));
        run_until_idle(100);

        // both ports from reset, held continuously: strict alternation
        do_reset();
        seen_port.delete();
        seen_cyc.delete();
        for (int i = 0; i < 2; i++) begin
            q[0].push_back(rand_txn(0));
            q[1].push_back(rand_txn(0));
        end
        run_until_idle(100);
        check_cadence("rr", 4, -1);

        // out-of-range boundary and last in-range word
        q[0].push_back(mk_txn(1'b0, 4'hF, AW'(6144), 32'h0));
        q[0].push_back(mk_txn(1'b0, 4'hF, AW'(8191), 32'h0));
        q[0].push_back(mk_txn(1'b1, 4'hF, AW'(6144), 32'h12345678));
        q[0].push_back(mk_txn(1'b1, 4'hF, AW'(6143), 32'hA5A55A5A));
        q[0].push_back(mk_txn(1'b0, 4'hF, AW'(6143), 32'h0));
        run_until_idle(100);

        // reset while a port-1 write is in ISSUE; port 0 must win afterwards
        q[0].push_back(mk_txn(1'b0, 4'hF, AW'(1), 32'h0));
        run_until_idle(100);
        q[1].push_back(mk_txn(1'b1, 4'hF, AW'(9), 32'hCAFEF00D));
        q[0].push_back(mk_txn(1'b0, 4'hF, AW'(9), 32'h0));
        rst_at_issue = 1'b1;
        run_until_idle(100);
        q[0].push_back(mk_txn(1'b0, 4'hF, AW'(9), 32'h0));
        run_until_idle(100);

        // port 1 alone: back-to-back at the 3-cycle cadence
        seen_port.delete();
        seen_cyc.delete();
        for (int i = 0; i < 10; i++) q[1].push_back(rand_txn(0));
        run_until_idle(200);
        check_cadence("solo", 10, 1);

        // random mix with gaps and occasional out-of-range addresses
        raise_pct = 60;
        for (int i = 0; i < 200; i++) q[$urandom_range(0, NREQ - 1)].push_back(rand_txn(10));
        run_until_idle(5000);
        check_eq("drained", pending(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
